// File: rtl/alt_pattern_detector.sv
// Serial detector for runs of RUN_LEN alternating bits, with optional overlap,
// start-bit qualification and a saturating match counter.
module alt_pattern_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    localparam int RLW    = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             overlap,
    input  logic             start_chk,
    input  logic             start_val,
    input  logic             clr,
    output logic             y,
    output logic [RLW-1:0]   run_len,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [RLW-1:0] RL_MAX = RLW'(RUN_LEN);
    localparam logic [RLW:0]   RL_CMP = (RLW+1)'(RUN_LEN);

    state_t         state, state_nx;
    logic           last, last_nx;
    logic [RLW-1:0] run_len_nx;
    logic [RLW:0]   rl_inc;
    logic           accept;
    logic           hit;

    assign accept = !start_chk || (a == start_val);
    assign rl_inc = {1'b0, run_len} + (RLW+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b0;
            run_len   <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            run_len <= run_len_nx;
            y       <= hit;
            // clear wins over a coincident hit
            if (clr)
                match_cnt <= '0;
            else if (hit && match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        last_nx    = last;
        run_len_nx = run_len;
        hit        = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nx   = RUN;
                        last_nx    = a;
                        run_len_nx = RLW'(1);
                    end else begin
                        run_len_nx = '0;
                    end
                end
                RUN: begin
                    if (a != last) begin
                        last_nx = a;
                        if (rl_inc < RL_CMP) begin
                            run_len_nx = rl_inc[RLW-1:0];
                        end else begin
                            hit = 1'b1;
                            // overlap keeps the run alive so each further alternation hits again
                            if (overlap) begin
                                run_len_nx = RL_MAX;
                            end else begin
                                state_nx   = IDLE;
                                run_len_nx = '0;
                            end
                        end
                    end else if (accept) begin
                        last_nx    = a;
                        run_len_nx = RLW'(1);
                    end else begin
                        state_nx   = IDLE;
                        run_len_nx = '0;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    run_len_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/alt_pattern_detector.md
ALT_PATTERN_DETECTOR -- requirements
Module: alt_pattern_detector

Interface
REQ-001 Parameter RUN_LEN, default 4: number of consecutive alternating bits that constitute a match; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  sample-valid; a is consumed only on edges where en=1.
REQ-006 a  input  1  serial data bit.
REQ-007 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 start_chk  input  1  1 = a run may only begin with a bit equal to start_val.
REQ-009 start_val  input  1  required first bit of a run when start_chk=1.
REQ-010 clr  input  1  synchronous clear of match_cnt.
REQ-011 y  output  1  registered one-cycle match pulse.
REQ-012 run_len  output  ceil(log2(RUN_LEN+1))  current alternating run length, registered.
REQ-013 match_cnt  output  CNT_W  saturating count of matches, registered.

Function
REQ-014 Terms: "sample" = rising edge with en=1; "accept" = start_chk=0 or a==start_val.
REQ-015 FSM states: IDLE (no run in progress) and RUN (run_len>=1, last sampled bit held in an internal register).
REQ-016 Edge with en=0: state, last bit, run_len and match_cnt held (except clr); y=0 after that edge.
REQ-017 IDLE, sample, accept: go to RUN, run_len=1, last=a; if not accept: stay IDLE, run_len=0.
REQ-018 RUN, sample, a!=last, run_len+1<RUN_LEN: run_len increments, last=a, y=0.
REQ-019 RUN, sample, a!=last, run_len+1>=RUN_LEN: "hit"; y=1 on the following cycle (latency 1 edge from the completing sample).
REQ-020 On hit with overlap=1: stay RUN, run_len saturates at RUN_LEN, last=a; every further alternating sample is another hit.
REQ-021 On hit with overlap=0: go IDLE, run_len=0; the completing bit is not reused; the next sample is evaluated per REQ-017.
REQ-022 RUN, sample, a==last (run broken): if accept, stay RUN with run_len=1, last=a; else go IDLE, run_len=0; y=0.
REQ-023 y is high for exactly one clock per hit; consecutive hits yield y high on consecutive sampled cycles.
REQ-024 match_cnt increments by 1 on each hit and saturates at 2^CNT_W-1 (no wrap).
REQ-025 clr=1: match_cnt=0 on that edge; clr has priority over a simultaneous hit (result 0); clr does not affect FSM, run_len or y.
REQ-026 overlap, start_chk, start_val are evaluated at each sample; a change mid-run does not reset run_len, only affects subsequent decisions.
REQ-027 Hit in overlap mode when run_len is already RUN_LEN does not change run_len.

Reset
REQ-028 rst=1 forces immediately (without clk): state IDLE, last=0, run_len=0, y=0, match_cnt=0.
REQ-029 While rst=1 all inputs are ignored; first sample is evaluated on the first rising edge after rst deasserts.
REQ-030 rst asserted mid-run or during a y pulse discards the run; no hit is counted or reported for it.

Verification
REQ-031 RUN_LEN=4, overlap=0, start_chk=0, a=0,1,0,1,0,1,0,1 every cycle -> y pulses after 4th and 8th samples only; match_cnt=2.
REQ-032 Same stream, overlap=1 -> y high after samples 4,5,6,7,8; match_cnt=5; run_len holds 4 from sample 4.
REQ-033 overlap=0, a=0,1,1,0,1,0 -> run restarts at 3rd bit (run_len 1), y pulses after 6th sample only; match_cnt=1.
REQ-034 start_chk=1, start_val=1, a=0,1,0,1,0 -> 1st bit rejected (run_len 0), y after 5th sample; en=0 gaps inserted between bits give identical result.
REQ-035 rst pulsed asynchronously after 3 alternating samples -> y, run_len, match_cnt 0 immediately; next 3 alternating samples produce no y.
REQ-036 CNT_W=2, overlap=1, 6 hits -> match_cnt 1,2,3,3,3,3; clr coincident with a hit -> match_cnt=0.
